// File: rtl/srl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srl_pkg
// Description : Shared state encoding and size defaults for the multicycle
//               logical-right-shift unit.
// Revision    : 1.0
// ============================================================================
package srl_pkg;

    localparam int c_WIDTH = 8;
    localparam int c_AMT_W = 3;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/srl_multicycle_8bit_if.sv
`default_nettype none
// ============================================================================
// Module      : srl_multicycle_8bit_if
// Description : Request/result bundle between the requester and the shifter.
// Revision    : 1.0
// ============================================================================
interface srl_multicycle_8bit_if #(
    parameter int WIDTH = srl_pkg::c_WIDTH,
    parameter int AMT_W = srl_pkg::c_AMT_W
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, x, amt,
        input  f, cout, busy, done
    );

    modport slave (
        input  start, x, amt,
        output f, cout, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/srl_step_8bit.sv
`default_nettype none
// ============================================================================
// Module      : srl_step_8bit
// Description : Combinational single-position logical right shift.
// Revision    : 1.0
// ============================================================================
module srl_step_8bit #(
    parameter int WIDTH = srl_pkg::c_WIDTH
) (
    input  wire logic [WIDTH-1:0] x,
    output logic      [WIDTH-1:0] f,
    output logic                  cout
);

    assign f    = {1'b0, x[WIDTH-1:1]};
    assign cout = x[0];

endmodule
`default_nettype wire

// File: rtl/srl_multicycle_8bit.sv
`default_nettype none
// ============================================================================
// Module      : srl_multicycle_8bit
// Description : Sequential shift-by-N logical right shifter, one bit per clock.
// Revision    : 1.0
// ============================================================================
module srl_multicycle_8bit
    import srl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int AMT_W = c_AMT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    srl_multicycle_8bit_if.slave  bus
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [AMT_W-1:0] r_count;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic [WIDTH-1:0] w_step_f;
    logic             w_step_cout;
    logic             w_busy;
    logic             w_done;

    srl_step_8bit #(
        .WIDTH (WIDTH)
    ) u_step (
        .x    (r_f),
        .f    (w_step_f),
        .cout (w_step_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.amt != '0) ? c_SHIFT : c_DONE;
                end
            end
            c_SHIFT: begin
                if (r_count == AMT_W'(1)) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Status flags decode only the state register, so no input reaches them.
    always_comb begin
        w_busy = (r_state != c_IDLE);
        w_done = (r_state == c_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_f     <= bus.x;
                        r_count <= bus.amt;
                        r_cout  <= 1'b0;
                    end
                end
                c_SHIFT: begin
                    r_f     <= w_step_f;
                    r_cout  <= w_step_cout;
                    r_count <= r_count - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.f    = r_f;
    assign bus.cout = r_cout;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule
`default_nettype wire
